// File: rtl/invader_grid_renderer_pkg.sv
// Shared constants and types for the invader grid renderer slice.
// Optional feature macro: INVADER_ANIM_EN (two-frame sprite animation).
package invader_pkg;

  localparam int H_VISIBLE   = 640;
  localparam int V_VISIBLE   = 480;
  localparam int CELL_W_LOG2 = 6;
  localparam int CELL_H_LOG2 = 5;
  localparam int SPR_W       = 16;
  localparam int SPR_H       = 8;

  localparam logic [7:0] COLOUR_WHITE = {3'h7, 3'h7, 2'h3};
  localparam logic [7:0] COLOUR_BLACK = 8'h00;

  typedef enum logic [1:0] {
    RIGHT  = 2'd0,
    LEFT   = 2'd1,
    LANDED = 2'd2
  } march_state_t;

endpackage

// File: rtl/invader_grid_renderer_if.sv
// Video-side bundle of the invader grid renderer: timing-generator inputs,
// alive mask, pixel/sync outputs and the grid state exported to game logic.
// The master side is whoever drives the pixel stream (timing generator / game).
interface invader_grid_renderer_if #(
  parameter int COLS = 8,
  parameter int ROWS = 5
);

  logic                   enable;
  logic [9:0]             hPos;
  logic [9:0]             vPos;
  logic                   hSync_in;
  logic                   vSync_in;
  logic [COLS*ROWS-1:0]   alive;

  logic [2:0]             red;
  logic [2:0]             green;
  logic [1:0]             blue;
  logic                   hSync;
  logic                   vSync;
  logic [9:0]             grid_x;
  logic [9:0]             grid_y;
  logic                   landed;

  modport master (
    output enable, hPos, vPos, hSync_in, vSync_in, alive,
    input  red, green, blue, hSync, vSync, grid_x, grid_y, landed
  );

  modport slave (
    input  enable, hPos, vPos, hSync_in, vSync_in, alive,
    output red, green, blue, hSync, vSync, grid_x, grid_y, landed
  );

endinterface

// File: rtl/invader_grid_renderer_sprite_rom.sv
// 16x8 invader sprite ROM, one row per lookup, bit 15 is the leftmost texel.
// With INVADER_ANIM_EN defined a second animation frame is selected by anim.
module invader_sprite_rom
  import invader_pkg::*;
(
  input  logic [2:0]       sy,
`ifdef INVADER_ANIM_EN
  input  logic             anim,
`endif
  output logic [SPR_W-1:0] row
);

  logic [SPR_W-1:0] frame0_row;

  // Frame 0 artwork (the only frame when animation is disabled)
  always_comb begin
    case (sy)
      3'd0:    frame0_row = 16'h83C1;
      3'd1:    frame0_row = 16'h1FF8;
      3'd2:    frame0_row = 16'h3FFC;
      3'd3:    frame0_row = 16'h6DB6;
      3'd4:    frame0_row = 16'hFFFF;
      3'd5:    frame0_row = 16'h2664;
      3'd6:    frame0_row = 16'h4812;
      default: frame0_row = 16'h8421;
    endcase
  end

`ifdef INVADER_ANIM_EN
  logic [SPR_W-1:0] frame1_row;

  // Frame 1 artwork, legs and arms in the alternate pose
  always_comb begin
    case (sy)
      3'd0:    frame1_row = 16'h03C0;
      3'd1:    frame1_row = 16'h9FF9;
      3'd2:    frame1_row = 16'hBFFD;
      3'd3:    frame1_row = 16'hEDB7;
      3'd4:    frame1_row = 16'h7FFE;
      3'd5:    frame1_row = 16'h1248;
      3'd6:    frame1_row = 16'h2424;
      default: frame1_row = 16'h4002;
    endcase
  end

  assign row = anim ? frame1_row : frame0_row;
`else
  assign row = frame0_row;
`endif

endmodule

// File: rtl/invader_grid_renderer.sv
// Invader grid renderer: two-stage pixel pipeline behind the VGA timing
// generator, matching sync delay, per-frame tick detector and march FSM.
// Optional feature macro: INVADER_ANIM_EN (sprite frame toggles each march step).
module invader_grid_renderer
  import invader_pkg::*;
#(
  parameter int COLS         = 8,
  parameter int ROWS         = 5,
  parameter int X_START      = 64,
  parameter int Y_START      = 48,
  parameter int STEP_X       = 8,
  parameter int STEP_Y       = 16,
  parameter int MARCH_FRAMES = 30,
  parameter int LAND_Y       = 440
) (
  input logic                    clk,
  input logic                    reset,
  invader_grid_renderer_if.slave vid
);

  localparam int GRID_W = COLS << CELL_W_LOG2;
  localparam int GRID_H = ROWS << CELL_H_LOG2;
  localparam int IDX_W  = $clog2(COLS * ROWS);

  // Grid / march state
  march_state_t state, state_nxt;
  logic [9:0]   grid_x, grid_x_nxt;
  logic [9:0]   grid_y, grid_y_nxt;
  logic [5:0]   frame_cnt, frame_cnt_nxt;
  logic [9:0]   prev_vpos;
  logic         frame_tick;
`ifdef INVADER_ANIM_EN
  logic         anim, anim_nxt;
`endif

  // Stage 1 combinational geometry and registers
  logic [10:0]  rx, ry;
  logic         in_grid_c, visible_c;
  logic [2:0]   s1_col, s1_row;
  logic [4:0]   s1_sx;
  logic [3:0]   s1_sy;
  logic         s1_in_grid, s1_visible;

  // Stage 2 lookup and output registers
  logic [IDX_W-1:0] alive_idx;
  logic [SPR_W-1:0] sprite_row;
  logic             pix;
  logic [7:0]       rgb;
  logic             hs_d1, hs_d2, vs_d1, vs_d2;

  invader_sprite_rom u_rom (
    .sy   (s1_sy[2:0]),
`ifdef INVADER_ANIM_EN
    .anim (anim),
`endif
    .row  (sprite_row)
  );

  // Offset of the incoming pixel from the grid origin, in 11 bits so sums never wrap
  always_comb begin
    rx        = {1'b0, vid.hPos} - {1'b0, grid_x};
    ry        = {1'b0, vid.vPos} - {1'b0, grid_y};
    in_grid_c = ({1'b0, vid.hPos} >= {1'b0, grid_x}) && (rx < 11'(GRID_W)) &&
                ({1'b0, vid.vPos} >= {1'b0, grid_y}) && (ry < 11'(GRID_H));
    visible_c = (vid.hPos < 10'(H_VISIBLE)) && (vid.vPos < 10'(V_VISIBLE));
  end

  // Texel lookup for the registered cell position; sprite sits doubled at the cell top-left
  always_comb begin
    alive_idx = IDX_W'(s1_row) * IDX_W'(COLS) + IDX_W'(s1_col);
    pix       = s1_in_grid && s1_visible &&
                (s1_sx < 5'(SPR_W)) && (s1_sy < 4'(SPR_H)) &&
                vid.alive[alive_idx] &&
                sprite_row[4'(SPR_W - 1) - s1_sx[3:0]];
  end

  // Pixel pipeline and sync delay line, both advancing one stage per enable
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_col     <= '0;
      s1_row     <= '0;
      s1_sx      <= '0;
      s1_sy      <= '0;
      s1_in_grid <= 1'b0;
      s1_visible <= 1'b0;
      rgb        <= COLOUR_BLACK;
      hs_d1      <= 1'b0;
      hs_d2      <= 1'b0;
      vs_d1      <= 1'b0;
      vs_d2      <= 1'b0;
    end else if (vid.enable) begin
      s1_col     <= rx[8:6];
      s1_row     <= ry[7:5];
      s1_sx      <= rx[5:1];
      s1_sy      <= ry[4:1];
      s1_in_grid <= in_grid_c;
      s1_visible <= visible_c;
      rgb        <= pix ? COLOUR_WHITE : COLOUR_BLACK;
      hs_d1      <= vid.hSync_in;
      hs_d2      <= hs_d1;
      vs_d1      <= vid.vSync_in;
      vs_d2      <= vs_d1;
    end
  end

  // Previous enabled vPos, used to spot the single transition into line 480
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_vpos <= '0;
    end else if (vid.enable) begin
      prev_vpos <= vid.vPos;
    end
  end

  assign frame_tick = vid.enable && (vid.vPos == 10'(V_VISIBLE)) &&
                      (prev_vpos != 10'(V_VISIBLE));

  // March state register; the grid only moves on frame_tick, so never mid-frame
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RIGHT;
      grid_x    <= 10'(X_START);
      grid_y    <= 10'(Y_START);
      frame_cnt <= '0;
`ifdef INVADER_ANIM_EN
      anim      <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      grid_x    <= grid_x_nxt;
      grid_y    <= grid_y_nxt;
      frame_cnt <= frame_cnt_nxt;
`ifdef INVADER_ANIM_EN
      anim      <= anim_nxt;
`endif
    end
  end

  // Next march step: count frames, then move sideways or descend and reverse
  always_comb begin
    state_nxt     = state;
    grid_x_nxt    = grid_x;
    grid_y_nxt    = grid_y;
    frame_cnt_nxt = frame_cnt;
`ifdef INVADER_ANIM_EN
    anim_nxt      = anim;
`endif
    if (frame_tick) begin
      if (frame_cnt == 6'(MARCH_FRAMES - 1)) begin
        frame_cnt_nxt = '0;
        case (state)
          RIGHT: begin
            if (({1'b0, grid_x} + 11'(GRID_W + STEP_X)) > 11'(H_VISIBLE)) begin
              grid_y_nxt = grid_y + 10'(STEP_Y);
              state_nxt  = LEFT;
            end else begin
              grid_x_nxt = grid_x + 10'(STEP_X);
            end
          end
          LEFT: begin
            if ({1'b0, grid_x} < 11'(STEP_X)) begin
              grid_y_nxt = grid_y + 10'(STEP_Y);
              state_nxt  = RIGHT;
            end else begin
              grid_x_nxt = grid_x - 10'(STEP_X);
            end
          end
          default: ;
        endcase
        if (state != LANDED) begin
`ifdef INVADER_ANIM_EN
          anim_nxt = ~anim;
`endif
          if (({1'b0, grid_y_nxt} + 11'(GRID_H)) >= 11'(LAND_Y)) begin
            state_nxt = LANDED;
          end
        end
      end else begin
        frame_cnt_nxt = frame_cnt + 6'd1;
      end
    end
  end

  assign vid.red    = rgb[7:5];
  assign vid.green  = rgb[4:2];
  assign vid.blue   = rgb[1:0];
  assign vid.hSync  = hs_d2;
  assign vid.vSync  = vs_d2;
  assign vid.grid_x = grid_x;
  assign vid.grid_y = grid_y;
  assign vid.landed = (state == LANDED);

endmodule

// File: tb/tb_invader_grid_renderer.sv
// Self-checking bench for invader_grid_renderer: a frame-level model of the
// grid and sprite geometry predicts every output, with directed and random
// pixel streams. Honours INVADER_ANIM_EN when the design is built with it.
module tb_invader_grid_renderer;

  logic        clk;
  logic        reset;
  logic [39:0] alive_r;

  invader_grid_renderer_if #(.COLS(8), .ROWS(5)) bus();

  invader_grid_renderer dut (
    .clk   (clk),
    .reset (reset),
    .vid   (bus)
  );

  assign bus.alive = alive_r;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [15:0] SPR0 [0:7] = '{16'h83C1, 16'h1FF8, 16'h3FFC, 16'h6DB6,
                                         16'hFFFF, 16'h2664, 16'h4812, 16'h8421};
  localparam logic [15:0] SPR1 [0:7] = '{16'h03C0, 16'h9FF9, 16'hBFFD, 16'hEDB7,
                                         16'h7FFE, 16'h1248, 16'h2424, 16'h4002};

  typedef struct packed {
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic check_en = 1'b0;

  // Model state: grid origin, direction (0 right, 1 left, 2 landed), frame count, anim
  int   m_gx, m_gy, m_dir, m_fc, m_anim, m_prev_v;
  exp_t m_q[$];
  exp_t m_out;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // What a screen pixel must show, straight from the grid geometry
  function automatic logic [7:0] model_pixel(int h, int v, int gx, int gy,
                                             logic [39:0] alv, int frame);
    int dx, dy, c, r, ox, oy;
    logic [15:0] line;
    if (h >= 640 || v >= 480) return 8'h00;
    if (h < gx || v < gy) return 8'h00;
    dx = h - gx;
    dy = v - gy;
    if (dx >= 512 || dy >= 160) return 8'h00;
    c  = dx / 64;
    r  = dy / 32;
    ox = dx % 64;
    oy = dy % 32;
    if (ox >= 32 || oy >= 16) return 8'h00;
    if (!alv[r*8 + c]) return 8'h00;
    line = (frame == 1) ? SPR1[oy/2] : SPR0[oy/2];
    return line[15 - ox/2] ? 8'hFF : 8'h00;
  endfunction

  task automatic model_march();
    if (m_dir == 2) return;
    if (m_dir == 0) begin
      if (m_gx + 512 + 8 > 640) begin m_gy += 16; m_dir = 1; end
      else m_gx += 8;
    end else begin
      if (m_gx < 8) begin m_gy += 16; m_dir = 0; end
      else m_gx -= 8;
    end
`ifdef INVADER_ANIM_EN
    m_anim ^= 1;
`endif
    if (m_gy + 160 >= 440) m_dir = 2;
  endtask

  // Drive one clock of inputs, then advance the model with what the DUT saw
  task automatic apply_stimulus(input logic en, input int h, input int v,
                                input logic hs, input logic vs, input logic rst);
    exp_t e;
    @(negedge clk);
    reset        = rst;
    bus.enable   = en;
    bus.hPos     = 10'(h);
    bus.vPos     = 10'(v);
    bus.hSync_in = hs;
    bus.vSync_in = vs;
    @(posedge clk);
    if (rst) begin
      m_gx = 64; m_gy = 48; m_dir = 0; m_fc = 0; m_anim = 0; m_prev_v = 0;
      m_q = {};
      m_q.push_back('0);
      m_out = '0;
      check_en = 1'b1;
    end else if (en) begin
      e.rgb = model_pixel(h, v, m_gx, m_gy, alive_r, m_anim);
      e.hs  = hs;
      e.vs  = vs;
      m_q.push_back(e);
      m_out = m_q.pop_front();
      if (v == 480 && m_prev_v != 480) begin
        if (m_fc == 29) begin m_fc = 0; model_march(); end
        else m_fc++;
      end
      m_prev_v = v;
    end
    #1;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023),
                   1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic flush();
    apply_stimulus(1'b1, 700, 500, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 700, 500, 1'b0, 1'b0, 1'b0);
  endtask

  // One frame: optional random pixels (mostly inside the grid), then vblank entry
  task automatic run_frame(input int pixels, input logic rnd_alive);
    int h, v;
    for (int i = 0; i < pixels; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        h = m_gx + $urandom_range(0, 523);
        v = m_gy + $urandom_range(0, 167);
      end else begin
        h = $urandom_range(0, 799);
        v = $urandom_range(0, 524);
      end
      apply_stimulus(1'($urandom_range(0, 2) != 0), h, v, 1'($urandom), 1'($urandom), 1'b0);
    end
    apply_stimulus(1'b1, 700, 480, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 700, 490, 1'b0, 1'b1, 1'b0);
    if (rnd_alive) alive_r = {$urandom, $urandom} | {$urandom, $urandom};
  endtask

  // Every cycle after reset: outputs must match the model
  always @(negedge clk) begin
    if (check_en) begin
      check_output("pixel_sync", {bus.red, bus.green, bus.blue, bus.hSync, bus.vSync},
                   {m_out.rgb, m_out.hs, m_out.vs});
      check_output("grid_state", {bus.grid_x, bus.grid_y, bus.landed},
                   {10'(m_gx), 10'(m_gy), (m_dir == 2)});
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int land_gx, land_gy, frames;
    logic [39:0] all_alive;
    logic [39:0] holed;
    all_alive = '1;
    holed     = all_alive;
    holed[10] = 1'b0;

    reset = 1'b1; bus.enable = 1'b0; bus.hPos = '0; bus.vPos = '0;
    bus.hSync_in = 1'b0; bus.vSync_in = 1'b0; alive_r = all_alive;
    apply_stimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 0, 0, 1'b0, 1'b0, 1'b1);
    $display("[TB] reset applied");

    check_output("reset_grid_x", bus.grid_x, 64);
    check_output("reset_grid_y", bus.grid_y, 48);
    check_output("reset_landed", bus.landed, 0);
    check_output("reset_rgb", {bus.red, bus.green, bus.blue}, 8'h00);

    // Origin pixel, enable every other clock, sync pattern to expose the delay
    apply_stimulus(1'b1, 64, 48, 1'b1, 1'b0, 1'b0);
    idle();
    apply_stimulus(1'b1, 0, 0, 1'b0, 1'b1, 1'b0);
    check_output("origin_rgb", {bus.red, bus.green, bus.blue}, 8'hFF);
    check_output("origin_hsync", bus.hSync, 1);
    check_output("origin_vsync", bus.vSync, 0);
    idle();
    apply_stimulus(1'b1, 10, 10, 1'b0, 1'b0, 1'b0);
    check_output("next_rgb", {bus.red, bus.green, bus.blue}, 8'h00);
    check_output("next_hsync", bus.hSync, 0);
    check_output("next_vsync", bus.vSync, 1);
    check_output("model_origin_texel", model_pixel(64, 48, 64, 48, all_alive, 0), 8'hFF);

    // Dead invader (c=2,r=1): its cell goes black, the neighbour keeps drawing
    flush();
    alive_r = holed;
    for (int y = 76; y < 100; y += 3) begin
      for (int x = 184; x < 232; x += 3) begin
        apply_stimulus(1'b1, x, y, 1'b0, 1'b0, 1'b0);
        idle();
      end
    end
    apply_stimulus(1'b1, 256, 80, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 200, 85, 1'b0, 1'b0, 1'b0);
    check_output("neighbour_rgb", {bus.red, bus.green, bus.blue}, 8'hFF);
    apply_stimulus(1'b1, 700, 500, 1'b0, 1'b0, 1'b0);
    check_output("dead_cell_rgb", {bus.red, bus.green, bus.blue}, 8'h00);
    check_output("model_dead_cell", model_pixel(200, 85, 64, 48, holed, 0), 8'h00);
    check_output("model_live_cell", model_pixel(200, 85, 64, 48, all_alive, 0), 8'hFF);
    flush();
    alive_r = all_alive;

    // 30 frames per march step
    for (int f = 0; f < 29; f++) run_frame(0, 1'b0);
    check_output("frame29_grid_x", bus.grid_x, 64);
    run_frame(0, 1'b0);
    check_output("frame30_grid_x", bus.grid_x, 72);
    check_output("frame30_grid_y", bus.grid_y, 48);

    apply_stimulus(1'b1, 72, 48, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 700, 490, 1'b0, 1'b0, 1'b0);
`ifdef INVADER_ANIM_EN
    check_output("anim_step1_texel", {bus.red, bus.green, bus.blue}, 8'h00);
`else
    check_output("anim_step1_texel", {bus.red, bus.green, bus.blue}, 8'hFF);
`endif

    // Walk right to the edge, then descend and reverse
    for (int f = 0; f < 6 * 30; f++) run_frame(0, 1'b0);
    check_output("preload_grid_x", bus.grid_x, 120);
    for (int f = 0; f < 30; f++) run_frame(0, 1'b0);
    check_output("edge_grid_x", bus.grid_x, 128);
    check_output("edge_grid_y", bus.grid_y, 48);
    apply_stimulus(1'b1, 128, 48, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 700, 490, 1'b0, 1'b0, 1'b0);
    check_output("anim_step8_texel", {bus.red, bus.green, bus.blue}, 8'hFF);
    for (int f = 0; f < 30; f++) run_frame(0, 1'b0);
    check_output("descend_grid_x", bus.grid_x, 128);
    check_output("descend_grid_y", bus.grid_y, 64);
    for (int f = 0; f < 30; f++) run_frame(0, 1'b0);
    check_output("left_grid_x", bus.grid_x, 120);

    // Reset mid-line while marching left, with enable low
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 300 + i, 100, 1'b1, 1'b1, 1'b0);
    check_output("pre_reset_hsync", bus.hSync, 1);
    apply_stimulus(1'b0, 303, 100, 1'b1, 1'b1, 1'b1);
    check_output("midreset_grid_x", bus.grid_x, 64);
    check_output("midreset_grid_y", bus.grid_y, 48);
    check_output("midreset_rgb", {bus.red, bus.green, bus.blue}, 8'h00);
    check_output("midreset_syncs", {bus.hSync, bus.vSync}, 2'b00);
    check_output("midreset_landed", bus.landed, 0);

    // Random pixels and alive masks until the grid lands
    frames = 0;
    while (m_dir != 2 && frames < 9000) begin
      run_frame((frames % 8 == 0) ? 6 : 0, 1'b1);
      frames++;
    end
    check_output("landed_flag", bus.landed, 1);
    check_output("landed_grid_y", bus.grid_y, 288);
    check_output("landed_grid_x", bus.grid_x, 128);
    land_gx = m_gx;
    land_gy = m_gy;
    for (int f = 0; f < 70; f++) run_frame((f % 4 == 0) ? 6 : 0, 1'b1);
    check_output("frozen_grid_x", bus.grid_x, 32'(land_gx));
    check_output("frozen_grid_y", bus.grid_y, 32'(land_gy));
    check_output("frozen_landed", bus.landed, 1);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
